// File: rtl/eth_tx_arbiter_if.sv
// Bundle of the arbiter's per-input AXI-Stream lanes, merged output stream and grant status.
// slave is the arbiter's view; master is the view of whatever sources inputs and sinks the output.
interface eth_tx_arbiter_if #(
  parameter int DW  = 512,
  parameter int NCH = 4
);
  logic [NCH-1:0]    enable_mask;
  logic [NCH*DW-1:0] axis_in_tdata;
  logic [NCH-1:0]    axis_in_tlast;
  logic [NCH-1:0]    axis_in_tvalid;
  logic [NCH-1:0]    axis_in_tready;
  logic [DW-1:0]     axis_out_tdata;
  logic              axis_out_tlast;
  logic              axis_out_tvalid;
  logic              axis_out_tready;
  logic [2:0]        grant_id;
  logic              busy;

  modport slave (
    input  enable_mask, axis_in_tdata, axis_in_tlast, axis_in_tvalid, axis_out_tready,
    output axis_in_tready, axis_out_tdata, axis_out_tlast, axis_out_tvalid, grant_id, busy
  );

  modport master (
    output enable_mask, axis_in_tdata, axis_in_tlast, axis_in_tvalid, axis_out_tready,
    input  axis_in_tready, axis_out_tdata, axis_out_tlast, axis_out_tvalid, grant_id, busy
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Packet-atomic NCH:1 AXI-Stream arbiter (round-robin or fixed priority), 1-cycle latency via a 2-entry skid buffer.
// Only the granted input sees tready (buffer not full); others stall. ETH_TX_ARB_PKTCNT_EN adds per-input packet counters.
module eth_tx_arbiter #(
  parameter int DW       = 512,
  parameter int NCH      = 4,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  eth_tx_arbiter_if.slave   bus
`ifdef ETH_TX_ARB_PKTCNT_EN
  ,
  output logic [NCH*32-1:0] pkt_count
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PASS = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [2:0]     grant_q, grant_d;
  logic [2:0]     rr_ptr_q, rr_ptr_d;

  logic [NCH-1:0] elig;
  logic [2:0]     pick;
  logic           pick_vld;
  int             base;
  int             cand;

  logic [DW-1:0]  in_dat;
  logic           in_last;
  logic           in_vld;
  logic [NCH-1:0] tready;

  logic [DW:0]    buf_q [2];
  logic           buf_wr_q;
  logic           buf_rd_q;
  logic [1:0]     buf_cnt_q;
  logic           buf_full;
  logic           push;
  logic           pop;

  assign elig = bus.axis_in_tvalid & bus.enable_mask;

  // Round-robin starts one past the last grant; fixed priority always scans from input 0.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = 0;
    base     = (ARB_MODE == 0) ? int'(rr_ptr_q) + 1 : 0;
    for (int k = 0; k < NCH; k++) begin
      cand = (base + k) % NCH;
      for (int j = 0; j < NCH; j++) begin
        if (!pick_vld && (j == cand) && elig[j]) begin
          pick_vld = 1'b1;
          pick     = 3'(j);
        end
      end
    end
  end

  always_comb begin
    in_dat  = '0;
    in_last = 1'b0;
    in_vld  = 1'b0;
    tready  = '0;
    for (int j = 0; j < NCH; j++) begin
      if (grant_q == 3'(j)) begin
        in_dat    = bus.axis_in_tdata[j*DW +: DW];
        in_last   = bus.axis_in_tlast[j];
        in_vld    = bus.axis_in_tvalid[j];
        tready[j] = (state_q == ST_PASS) && !buf_full;
      end
    end
  end

  assign buf_full = (buf_cnt_q == 2'd2);
  assign push     = (state_q == ST_PASS) && in_vld && !buf_full;
  assign pop      = (buf_cnt_q != 2'd0) && bus.axis_out_tready;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d  = ST_PASS;
          grant_d  = pick;
          rr_ptr_d = pick;
        end
      end
      ST_PASS: begin
        if (push && in_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= 3'd0;
      rr_ptr_q <= 3'(NCH - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Emptying the buffer on reset is what drops a truncated packet's in-flight beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_wr_q  <= 1'b0;
      buf_rd_q  <= 1'b0;
      buf_cnt_q <= 2'd0;
    end else begin
      if (push) buf_wr_q <= ~buf_wr_q;
      if (pop)  buf_rd_q <= ~buf_rd_q;
      buf_cnt_q <= buf_cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[buf_wr_q] <= {in_last, in_dat};
  end

  assign bus.axis_in_tready  = tready;
  assign bus.axis_out_tvalid = (buf_cnt_q != 2'd0);
  assign bus.axis_out_tlast  = buf_q[buf_rd_q][DW];
  assign bus.axis_out_tdata  = buf_q[buf_rd_q][DW-1:0];
  assign bus.busy            = (state_q == ST_PASS);
  assign bus.grant_id        = grant_q;

`ifdef ETH_TX_ARB_PKTCNT_EN
  logic [31:0] cnt_q [NCH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= 32'd0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push && in_last && (grant_q == 3'(i))) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_cnt
    assign pkt_count[i*32 +: 32] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench: a grant table applied to a round-robin and a fixed-priority instance side by side,
// then packet sequences for throughput, starvation, stalls, mask changes and mid-packet reset.
module tb_eth_tx_arbiter;
  localparam int DW  = 16;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    mask;
  logic [NCH-1:0]    in_vld;
  logic [NCH-1:0]    in_last;
  logic [NCH*DW-1:0] in_dat;
  logic              out_rdy;

  always #5 clk = ~clk;

  eth_tx_arbiter_if #(.DW(DW), .NCH(NCH)) if0 ();
  eth_tx_arbiter_if #(.DW(DW), .NCH(NCH)) if1 ();

  assign if0.enable_mask     = mask;
  assign if0.axis_in_tdata   = in_dat;
  assign if0.axis_in_tlast   = in_last;
  assign if0.axis_in_tvalid  = in_vld;
  assign if0.axis_out_tready = out_rdy;
  assign if1.enable_mask     = mask;
  assign if1.axis_in_tdata   = in_dat;
  assign if1.axis_in_tlast   = in_last;
  assign if1.axis_in_tvalid  = in_vld;
  assign if1.axis_out_tready = out_rdy;

`ifdef ETH_TX_ARB_PKTCNT_EN
  logic [NCH*32-1:0] pc0, pc1;
  eth_tx_arbiter #(.DW(DW), .NCH(NCH), .ARB_MODE(0)) dut0 (.clk(clk), .reset(rst), .bus(if0.slave), .pkt_count(pc0));
  eth_tx_arbiter #(.DW(DW), .NCH(NCH), .ARB_MODE(1)) dut1 (.clk(clk), .reset(rst), .bus(if1.slave), .pkt_count(pc1));
`else
  eth_tx_arbiter #(.DW(DW), .NCH(NCH), .ARB_MODE(0)) dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
  eth_tx_arbiter #(.DW(DW), .NCH(NCH), .ARB_MODE(1)) dut1 (.clk(clk), .reset(rst), .bus(if1.slave));
`endif

  typedef struct {
    logic [3:0] mask;
    logic [3:0] vld;
    logic       bsy;
    logic [2:0] g_rr;
    logic [2:0] g_fp;
  } vec_t;

  vec_t tbl [13];

  int checks = 0;
  int errors = 0;

  int pk_left [NCH];
  int pk_len  [NCH];
  int beat_no [NCH];
  int pk_no   [NCH];
  int rdy_pat [4];
  int rdy_len;
  int cyc;
  logic        hold_chk;
  logic        fp_watch;
  logic [DW:0] prev_out;
  logic [DW:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdat(input int i, input int p, input int b);
    return {4'(i), 4'(p), 8'(b)};
  endfunction

  task automatic push_pkt(input int i, input int p, input int len);
    for (int b = 0; b < len; b++) exp_q.push_back({(b == len - 1), mkdat(i, p, b)});
  endtask

  task automatic init_src();
    for (int i = 0; i < NCH; i++) begin
      pk_left[i] = 0;
      pk_len[i]  = 1;
      beat_no[i] = 0;
      pk_no[i]   = 0;
    end
    exp_q.delete();
    hold_chk   = 1'b0;
    fp_watch   = 1'b0;
    cyc        = 0;
    rdy_len    = 1;
    rdy_pat[0] = 1;
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      in_vld[i]              = (pk_left[i] > 0);
      in_last[i]             = (beat_no[i] == pk_len[i] - 1);
      in_dat[i*DW +: DW]     = mkdat(i, pk_no[i], beat_no[i]);
    end
    out_rdy = (rdy_pat[cyc % rdy_len] != 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a falling edge: checks outputs, then advances the sources by one clock.
  task automatic step(input int d);
    logic [NCH-1:0] rdy, acc;
    logic           ov, ol;
    logic [DW-1:0]  od;
    if (d == 0) begin
      rdy = if0.axis_in_tready; ov = if0.axis_out_tvalid; ol = if0.axis_out_tlast; od = if0.axis_out_tdata;
    end else begin
      rdy = if1.axis_in_tready; ov = if1.axis_out_tvalid; ol = if1.axis_out_tlast; od = if1.axis_out_tdata;
    end
    acc = in_vld & rdy;
    if (hold_chk) chk("stall_hold", {ov, ol, od}, {1'b1, prev_out});
    if (ov && out_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got %0h expected no beat", {ol, od});
      end else begin
        chk("out_beat", {ol, od}, exp_q.pop_front());
      end
    end
    hold_chk = ov && !out_rdy;
    prev_out = {ol, od};
    if (fp_watch && d == 1 && pk_left[1] > 0) chk("fp_tready3", rdy[3], 0);
    @(posedge clk); #1;
    for (int i = 0; i < NCH; i++) begin
      if (acc[i]) begin
        beat_no[i]++;
        if (beat_no[i] == pk_len[i]) begin
          beat_no[i] = 0;
          pk_no[i]++;
          pk_left[i]--;
        end
      end
    end
    cyc++;
    drive();
    @(negedge clk);
  endtask

  task automatic run(input int d, input int maxc);
    for (int n = 0; n < maxc && exp_q.size() > 0; n++) step(d);
    chk("beats_missing", exp_q.size(), 0);
  endtask

  initial begin
    logic [3:0] oh;
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 3'd0, 3'd0};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 3'd1, 3'd0};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 3'd2, 3'd0};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 3'd3, 3'd0};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 3'd0, 3'd0};
    tbl[5]  = '{4'hF, 4'hA, 1'b1, 3'd1, 3'd1};
    tbl[6]  = '{4'hF, 4'hA, 1'b1, 3'd3, 3'd1};
    tbl[7]  = '{4'hF, 4'hA, 1'b1, 3'd1, 3'd1};
    tbl[8]  = '{4'h0, 4'hF, 1'b0, 3'd0, 3'd0};
    tbl[9]  = '{4'h4, 4'hF, 1'b1, 3'd2, 3'd2};
    tbl[10] = '{4'hF, 4'h1, 1'b1, 3'd0, 3'd0};
    tbl[11] = '{4'h9, 4'hF, 1'b1, 3'd3, 3'd0};
    tbl[12] = '{4'h6, 4'hC, 1'b1, 3'd2, 3'd2};

    rst = 1'b1; mask = '0; in_vld = '0; in_last = '0; in_dat = '0; out_rdy = 1'b1;
    init_src();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy0", if0.busy, 0);
    chk("rst_grant0", if0.grant_id, 0);
    chk("rst_tready0", if0.axis_in_tready, 0);
    chk("rst_ovld0", if0.axis_out_tvalid, 0);
    chk("rst_busy1", if1.busy, 0);
    chk("rst_ovld1", if1.axis_out_tvalid, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single-beat packets; both instances see identical inputs.
    in_last = '1;
    for (int i = 0; i < NCH; i++) in_dat[i*DW +: DW] = 16'hA000 | 16'(i);
    for (int v = 0; v < 13; v++) begin
      @(posedge clk); #1;
      mask   = tbl[v].mask;
      in_vld = tbl[v].vld;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_busy_rr", v), if0.busy, tbl[v].bsy);
      chk($sformatf("v%0d_busy_fp", v), if1.busy, tbl[v].bsy);
      if (tbl[v].bsy) begin
        chk($sformatf("v%0d_grant_rr", v), if0.grant_id, tbl[v].g_rr);
        chk($sformatf("v%0d_grant_fp", v), if1.grant_id, tbl[v].g_fp);
      end
      oh = tbl[v].bsy ? 4'(1 << tbl[v].g_rr) : 4'b0;
      chk($sformatf("v%0d_tready_rr", v), if0.axis_in_tready, oh);
      oh = tbl[v].bsy ? 4'(1 << tbl[v].g_fp) : 4'b0;
      chk($sformatf("v%0d_tready_fp", v), if1.axis_in_tready, oh);
      @(posedge clk); #1 in_vld = '0;
      @(negedge clk);
      chk($sformatf("v%0d_done_busy", v), if0.busy, 0);
      chk($sformatf("v%0d_ovld_rr", v), if0.axis_out_tvalid, tbl[v].bsy);
      if (tbl[v].bsy) begin
        chk($sformatf("v%0d_odat_rr", v), {if0.axis_out_tlast, if0.axis_out_tdata}, {1'b1, 16'hA000 | 16'(tbl[v].g_rr)});
        chk($sformatf("v%0d_odat_fp", v), {if1.axis_out_tlast, if1.axis_out_tdata}, {1'b1, 16'hA000 | 16'(tbl[v].g_fp)});
      end
    end
`ifdef ETH_TX_ARB_PKTCNT_EN
    chk("pc_rr", pc0, {32'd3, 32'd3, 32'd3, 32'd3});
    chk("pc_fp", pc1, {32'd0, 32'd2, 32'd3, 32'd7});
`endif

    // All four inputs with two 3-beat packets each, round-robin.
    init_src();
    mask = 4'hF;
    for (int i = 0; i < NCH; i++) begin pk_left[i] = 2; pk_len[i] = 3; end
    for (int p = 0; p < 2; p++) for (int i = 0; i < NCH; i++) push_pkt(i, p, 3);
    drive();
    do_reset();
    run(0, 150);

    // Fixed priority: input 1 keeps winning while it has packets.
    init_src();
    pk_left[1] = 3; pk_len[1] = 2;
    pk_left[3] = 1; pk_len[3] = 2;
    push_pkt(1, 0, 2); push_pkt(1, 1, 2); push_pkt(1, 2, 2); push_pkt(3, 0, 2);
    fp_watch = 1'b1;
    drive();
    do_reset();
    run(1, 100);

    // 8-beat packet with output ready pattern 1,0,0,1.
    init_src();
    pk_left[2] = 1; pk_len[2] = 8;
    rdy_pat[0] = 1; rdy_pat[1] = 0; rdy_pat[2] = 0; rdy_pat[3] = 1; rdy_len = 4;
    push_pkt(2, 0, 8);
    drive();
    do_reset();
    run(0, 100);

    // Only input 1 enabled; mask cleared mid-packet must not cut the packet.
    init_src();
    mask = 4'b0010;
    for (int i = 0; i < NCH; i++) begin pk_left[i] = 1; pk_len[i] = 4; end
    push_pkt(1, 0, 4);
    drive();
    do_reset();
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
      step(0);
      if (n == 2) begin
        mask = 4'b0000;
        chk("mask_mid_busy", if0.busy, 1);
      end
    end
    chk("mask_beats_missing", exp_q.size(), 0);
    repeat (3) step(0);
    chk("mask_after_busy", if0.busy, 0);
    chk("mask_after_ovld", if0.axis_out_tvalid, 0);

    // Reset after beat 3 of a 6-beat packet on input 2.
    init_src();
    mask = 4'hF;
    pk_left[2] = 1; pk_len[2] = 6;
    exp_q.push_back({1'b0, mkdat(2, 0, 0)});
    exp_q.push_back({1'b0, mkdat(2, 0, 1)});
    drive();
    do_reset();
    for (int n = 0; n < 40 && beat_no[2] < 3; n++) step(0);
    chk("rst_mid_beats_in", beat_no[2], 3);
    rst = 1'b1;
    #1;
    chk("rst_mid_ovld", if0.axis_out_tvalid, 0);
    chk("rst_mid_busy", if0.busy, 0);
    chk("rst_mid_grant", if0.grant_id, 0);
    chk("rst_mid_tready", if0.axis_in_tready, 0);
    chk("rst_mid_beats_out", exp_q.size(), 0);
`ifdef ETH_TX_ARB_PKTCNT_EN
    chk("rst_mid_pc", pc0, 0);
`endif
    init_src();
    pk_left[0] = 1;
    pk_left[2] = 1; pk_no[2] = 1;
    pk_left[3] = 1;
    push_pkt(0, 0, 1); push_pkt(2, 1, 1); push_pkt(3, 0, 1);
    drive();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    step(0);
    chk("rst_rel_busy", if0.busy, 1);
    chk("rst_rel_grant", if0.grant_id, 0);
    run(0, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
